seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Display scanner that sits downstream of the six-digit clock counter. It takes the six 8-bit segment patterns (sec0, sec1, min0, min1, hour0, hour1) and time-multiplexes them onto one shared 8-bit segment bus with a one-hot digit select. The bus drives a common-segment 6-digit LED module. Each frame is taken from a single coherent snapshot of the inputs, and a blanking interval at the start of each digit slot suppresses ghosting.

## Interface
- DIV, default 1000: clock cycles per digit slot; legal range is DIV ≥ 2 and DIV > BLANK.
- BLANK, default 4: cycles at the start of each slot with all digits off; 0 disables blanking.
- SEL_ACTIVE_LOW, default 1: 1 means a selected digit drives 0 on dig_sel.
- SEG_ACTIVE_LOW, default 1: 1 means a lit segment drives 0 on seg.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  scan enable; 0 blanks the display and holds the scanner idle.
- sec0, sec1, min0, min1, hour0, hour1  in  8 each  segment patterns; bit = 1 means the segment is lit.
- dig_sel  out  6  digit select, one-hot when active; bit0 = sec0 … bit5 = hour1.
- seg  out  8  segment bus; polarity is set by SEG_ACTIVE_LOW.
- frame_start  out  1  one-cycle pulse marking a new snapshot and digit 0 slot.

## Operation
- States:
  - IDLE: reset, or en = 0.
  - SCAN.
- Internal registers:
  - slot counter cnt, width $clog2(DIV), range 0..DIV-1.
  - digit index idx, range 0..5.
  - snapshot registers snap[0..5], 8 bits each.
- IDLE:
  - cnt = 0, idx = 0.
  - dig_sel is all inactive; seg is all off.
  - If en = 1 is sampled: go to SCAN at (idx 0, cnt 0), load snap from the inputs, assert frame_start.
- SCAN, en = 1:
  - cnt increments each cycle.
  - When cnt = DIV-1: cnt goes to 0 and idx increments.
  - When idx = 5 and cnt = DIV-1: idx wraps to 0, snap loads all six inputs on the same edge, and frame_start is asserted.
- SCAN, en = 0 sampled: next state is IDLE; cnt, idx and outputs go to their IDLE values on that edge; snap is held.
- Output decode for the current (cnt, idx):
  - cnt < BLANK: dig_sel is all inactive and seg is all off.
  - otherwise: dig_sel activates bit idx only, and seg = snap[idx] with polarity applied.
- Inputs that change mid-frame are not displayed until the next snapshot, so a carry ripple never tears a frame.
- Frame period is 6·DIV cycles; each digit is lit for DIV-BLANK cycles per frame.

## Timing
- dig_sel, seg and frame_start are registered. They are loaded on the same edge that loads cnt/idx/state and always match the registered state of that cycle.
- frame_start is high for exactly one cycle: the first cycle of idx 0, cnt 0. It is never high in IDLE.
- Snapshot latency: input values sampled on the frame_start edge appear on seg in cycle BLANK of the digit's slot. For digit k this is k·DIV + BLANK cycles after frame_start rises.
- Reset values:
  - state IDLE, cnt 0, idx 0, snap all 0, frame_start 0.
  - dig_sel = 6'h3F if SEL_ACTIVE_LOW, else 6'h00.
  - seg = 8'hFF if SEG_ACTIVE_LOW, else 8'h00.
- Reset takes priority over en, including mid-slot and mid-frame; the clock edge with resetn = 0 produces the reset values.
- Re-enabling always restarts at digit 0 with a fresh snapshot. Partial frames are never resumed.
- No two digit-select bits are ever active in the same cycle. With BLANK ≥ 1, there are at least BLANK all-off cycles between consecutive lit digits.

## Test plan
- Reset:
  - Stimulus: resetn = 0 for 3 cycles with en = 1 and DIV = 8, BLANK = 2, defaults otherwise.
  - Response: dig_sel = 6'h3F, seg = 8'hFF, frame_start = 0 throughout.
- Basic scan:
  - Stimulus: release reset with en = 1 and inputs sec0 = 8'h3F, sec1 = 8'h06, min0 = 8'h5B, min1 = 8'h4F, hour0 = 8'h66, hour1 = 8'h6D.
  - Response: frame_start pulses one cycle after en is sampled, then every 48 cycles. Slot cycles 0–1 are blank. Slot 0 cycles 2–7 show dig_sel = 6'b111110, seg = 8'hC0. Slot 5 shows dig_sel = 6'b011111, seg = 8'h92.
- Coherence:
  - Stimulus: change hour1 from 8'h6D to 8'h06 at cycle 20 of a frame.
  - Response: that frame's slot 5 (cycles 40–47) still shows seg = 8'h92. The next frame shows 8'hF9.
- Enable drop:
  - Stimulus: deassert en at frame cycle 13 for 5 cycles, then reassert.
  - Response: outputs go inactive on the next edge and stay inactive. On re-enable, frame_start pulses and scanning restarts at digit 0 with current inputs.
- Mid-operation reset:
  - Stimulus: pulse resetn low for 1 cycle during slot 3.
  - Response: that edge gives reset values. After release, scanning resumes at digit 0 with a fresh snapshot and a frame_start pulse.
- Polarity and no-blank variant:
  - Stimulus: SEL_ACTIVE_LOW = 0, SEG_ACTIVE_LOW = 0, BLANK = 0, DIV = 4.
  - Response: dig_sel steps 6'b000001 → 6'b100000 every 4 cycles with no blank cycles, seg equals the raw snapshot, and dig_sel has exactly one bit set in every SCAN cycle.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// Bus between the clock counter / consumer and the seven-segment scanner:
// six segment patterns plus enable in, digit select / segment bus / frame pulse out.
interface seven_seg_scan_if;
    logic       en;
    logic [7:0] sec0, sec1, min0, min1, hour0, hour1;
    logic [5:0] dig_sel;
    logic [7:0] seg;
    logic       frame_start;

    modport master (
        output en, sec0, sec1, min0, min1, hour0, hour1,
        input  dig_sel, seg, frame_start
    );

    modport slave (
        input  en, sec0, sec1, min0, min1, hour0, hour1,
        output dig_sel, seg, frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Six-digit LED scanner: time-multiplexes a coherent per-frame snapshot of the
// segment patterns onto one segment bus with a one-hot digit select and blanking.
module seven_seg_digit_reg (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (!resetn)   q <= 8'h00;
        else if (load) q <= d;
    end
endmodule

module seven_seg_scan #(
    parameter int DIV            = 1000,
    parameter int BLANK          = 4,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    seven_seg_scan_if.slave   bus
);
    localparam int CW = $clog2(DIV);
    localparam int ND = 6;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t            state, nxt_state;
    logic [CW-1:0]     cnt, nxt_cnt;
    logic [2:0]        idx, nxt_idx;
    logic              load, nxt_fs;
    logic              in_blank, lit;
    logic [ND-1:0][7:0] in_vec, snap, nxt_snap;
    logic [5:0]        sel_act;
    logic [7:0]        seg_raw;

    assign in_vec = {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};

    // One snapshot register per digit; all load together so a frame never tears.
    for (genvar k = 0; k < ND; k++) begin : g_dig
        seven_seg_digit_reg u_reg (
            .clk    (clk),
            .resetn (resetn),
            .load   (load),
            .d      (in_vec[k]),
            .q      (snap[k])
        );
        assign nxt_snap[k] = load ? in_vec[k] : snap[k];
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        load      = 1'b0;
        nxt_fs    = 1'b0;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                nxt_idx = '0;
                if (bus.en) begin
                    nxt_state = SCAN;
                    load      = 1'b1;
                    nxt_fs    = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.en) begin
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end else if (cnt == CW'(DIV - 1)) begin
                    nxt_cnt = '0;
                    if (idx == 3'd5) begin
                        nxt_idx = '0;
                        load    = 1'b1;
                        nxt_fs  = 1'b1;
                    end else begin
                        nxt_idx = idx + 3'd1;
                    end
                end else begin
                    nxt_cnt = cnt + CW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs decode the next state so the registered outputs match cnt/idx.
    if (BLANK == 0) begin : g_noblank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (nxt_cnt < CW'(BLANK));
    end

    assign lit = (nxt_state == SCAN) && !in_blank;

    always_comb begin
        sel_act = '0;
        seg_raw = '0;
        if (lit) begin
            for (int k = 0; k < ND; k++) begin
                if (nxt_idx == 3'(k)) begin
                    sel_act[k] = 1'b1;
                    seg_raw    = nxt_snap[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            bus.frame_start <= 1'b0;
            bus.dig_sel     <= SEL_ACTIVE_LOW ? 6'h3F : 6'h00;
            bus.seg         <= SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            idx             <= nxt_idx;
            bus.frame_start <= nxt_fs;
            bus.dig_sel     <= SEL_ACTIVE_LOW ? ~sel_act : sel_act;
            bus.seg         <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two configurations driven in lockstep and compared
// every cycle against a position-in-frame reference model.
module tb_seven_seg_scan;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       en = 1'b0;
    logic [7:0] d [6];

    always #5 clk = ~clk;

    seven_seg_scan_if ifa ();
    seven_seg_scan_if ifb ();

    assign ifa.en = en;    assign ifb.en = en;
    assign ifa.sec0 = d[0];  assign ifb.sec0 = d[0];
    assign ifa.sec1 = d[1];  assign ifb.sec1 = d[1];
    assign ifa.min0 = d[2];  assign ifb.min0 = d[2];
    assign ifa.min1 = d[3];  assign ifb.min1 = d[3];
    assign ifa.hour0 = d[4]; assign ifb.hour0 = d[4];
    assign ifa.hour1 = d[5]; assign ifb.hour1 = d[5];

    seven_seg_scan #(.DIV(8), .BLANK(2), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
        dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
    seven_seg_scan #(.DIV(4), .BLANK(0), .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0))
        dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

    int nvec = 0;
    int nmis = 0;

    // Model: cycles elapsed since scanning began, plus the frame snapshot.
    int         dv [2] = '{8, 4};
    int         bl [2] = '{2, 0};
    bit         sl [2] = '{1'b1, 1'b0};
    bit         gl [2] = '{1'b1, 1'b0};
    bit         run [2];
    int         p [2];
    logic [7:0] sn [2][6];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl(input int i);
        if (!resetn) begin
            run[i] = 1'b0;
            p[i]   = 0;
            for (int k = 0; k < 6; k++) sn[i][k] = 8'h00;
        end else if (!en) begin
            run[i] = 1'b0;
        end else if (!run[i]) begin
            run[i] = 1'b1;
            p[i]   = 0;
            sn[i]  = d;
        end else begin
            p[i]++;
            if (p[i] % (6 * dv[i]) == 0) sn[i] = d;
        end
    endtask

    task automatic verify(input int i, input logic [5:0] ds, input logic [7:0] sg, input logic fs);
        int         slot;
        bit         lit;
        logic [5:0] act;
        logic [7:0] es;
        slot = (p[i] / dv[i]) % 6;
        lit  = run[i] && ((p[i] % dv[i]) >= bl[i]);
        act  = lit ? 6'(1 << slot) : 6'h00;
        es   = lit ? sn[i][slot] : 8'h00;
        if (gl[i]) es = ~es;
        chk(i == 0 ? "a_dig_sel" : "b_dig_sel", {2'b00, ds}, {2'b00, (sl[i] ? ~act : act)});
        chk(i == 0 ? "a_seg" : "b_seg", sg, es);
        chk(i == 0 ? "a_frame_start" : "b_frame_start", {7'd0, fs},
            {7'd0, (run[i] && (p[i] % (6 * dv[i]) == 0))});
        if (i == 1) chk("b_onehot", 8'($countones(ds)), run[i] ? 8'd1 : 8'd0);
    endtask

    task automatic step();
        @(posedge clk);
        mdl(0);
        mdl(1);
        #1;
        verify(0, ifa.dig_sel, ifa.seg, ifa.frame_start);
        verify(1, ifb.dig_sel, ifb.seg, ifb.frame_start);
    endtask

    initial begin
        d = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
        en = 1'b1;
        resetn = 1'b0;
        repeat (3) step();
        chk("reset_dig_sel", {2'b00, ifa.dig_sel}, 8'h3F);
        chk("reset_seg", ifa.seg, 8'hFF);

        resetn = 1'b1;
        step();                                  // frame position 0
        chk("first_frame_start", {7'd0, ifa.frame_start}, 8'd1);
        repeat (2) step();                       // position 2
        chk("slot0_dig_sel", {2'b00, ifa.dig_sel}, 8'h3E);
        chk("slot0_seg", ifa.seg, 8'hC0);
        chk("b_slot0_seg", ifb.seg, 8'h3F);
        repeat (18) step();                      // position 20
        d[5] = 8'h06;
        repeat (22) step();                      // position 42
        chk("coherent_dig_sel", {2'b00, ifa.dig_sel}, 8'h1F);
        chk("coherent_seg", ifa.seg, 8'h92);
        repeat (48) step();                      // position 90
        chk("next_frame_seg", ifa.seg, 8'hF9);
        repeat (19) step();                      // position 109, frame cycle 13

        en = 1'b0;
        repeat (5) step();
        chk("en_drop_dig_sel", {2'b00, ifa.dig_sel}, 8'h3F);
        for (int k = 0; k < 6; k++) d[k] = 8'($urandom);
        en = 1'b1;
        step();
        chk("reenable_frame_start", {7'd0, ifa.frame_start}, 8'd1);

        repeat (26) step();                      // slot 3 of the A scanner
        resetn = 1'b0;
        step();
        chk("midreset_seg", ifa.seg, 8'hFF);
        resetn = 1'b1;
        step();
        chk("post_reset_frame_start", {7'd0, ifa.frame_start}, 8'd1);

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) d[$urandom_range(0, 5)] = 8'($urandom);
            if ($urandom_range(0, 59) == 0) en = ~en;
            else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
            resetn = ($urandom_range(0, 149) != 0);
            step();
        end
        resetn = 1'b1;
        en = 1'b1;
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
